// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - shared widths, format codes, opcodes and the field packer
package inst_encoder_pkg;

    localparam int WORD      = 64;
    localparam int INST_SIZE = 32;

    typedef enum logic [2:0] {
        ENC_FMT_R     = 3'd0,
        ENC_FMT_I     = 3'd1,
        ENC_FMT_D     = 3'd2,
        ENC_FMT_CB    = 3'd3,
        ENC_FMT_B     = 3'd4,
        ENC_FMT_IW    = 3'd5,
        ENC_FMT_SHIFT = 3'd6,
        ENC_FMT_RSVD  = 3'd7
    } enc_fmt_e;

    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    // Opcode is left-justified; formats with wide immediates drop its low bits.
    function automatic logic [INST_SIZE-1:0] pack_inst(
        input enc_fmt_e        fmt,
        input logic [10:0]     op,
        input logic [4:0]      rd,
        input logic [4:0]      rn,
        input logic [4:0]      rm,
        input logic [WORD-1:0] imm
    );
        logic [INST_SIZE-1:0] w;
        case (fmt)
            ENC_FMT_R:     w = {op, rm, 6'b0, rn, rd};
            ENC_FMT_SHIFT: w = {op, 5'b0, imm[5:0], rn, rd};
            ENC_FMT_I:     w = {op[10:1], imm[11:0], rn, rd};
            ENC_FMT_D:     w = {op, imm[8:0], 2'b00, rn, rd};
            ENC_FMT_CB:    w = {op[10:3], imm[18:0], rd};
            ENC_FMT_B:     w = {op[10:5], imm[25:0]};
            ENC_FMT_IW:    w = {op[10:2], 2'b00, imm[15:0], rd};
            default:       w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imm_range_chk.sv
// rtl/imm_range_chk.sv - combinational check that an immediate fits a signed or unsigned field
module imm_range_chk
    import inst_encoder_pkg::*;
(
    input  logic [WORD-1:0] imm_i,
    input  logic [5:0]      width_i,
    input  logic            signed_i,
    output logic            fits_o
);

    logic [WORD-1:0] hi_mask;
    logic [WORD-1:0] hi_bits;

    // Signed fit: bits [63:N-1] all equal. Unsigned fit: bits [63:N] all zero.
    always_comb begin
        hi_mask = signed_i ? ({WORD{1'b1}} << (width_i - 6'd1)) : ({WORD{1'b1}} << width_i);
        hi_bits = imm_i & hi_mask;
        fits_o  = (hi_bits == '0) || (signed_i && (hi_bits == hi_mask));
    end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - two-stage LEGv8 instruction packer; INST_ENC_PCREL_EN makes CB/B targets absolute
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [10:0]          in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rn,
    input  logic [4:0]           in_rm,
    input  logic [WORD-1:0]      in_imm,
    input  logic                 addr_load,
    input  logic [ADDR_W-1:0]    addr_init,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INST_SIZE-1:0] out_inst,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic                 a_valid_q, a_valid_d;
    enc_fmt_e             a_fmt_q;
    logic [10:0]          a_op_q;
    logic [4:0]           a_rd_q, a_rn_q, a_rm_q;
    logic [WORD-1:0]      a_imm_q;
    logic                 b_valid_q, b_valid_d;
    logic [INST_SIZE-1:0] b_inst_q, b_inst_d;
    logic [ADDR_W-1:0]    b_addr_q, b_addr_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 a_adv, accept, reject, fits;
    logic                 need_chk, fmt_bad, align_bad, chk_signed;
    logic [5:0]           chk_w;
    logic [WORD-1:0]      eff_imm;

    assign a_adv    = a_valid_q && (!b_valid_q || out_ready);
    assign in_ready = !a_valid_q || a_adv;

    always_comb begin
        need_chk   = 1'b1;
        fmt_bad    = 1'b0;
        align_bad  = 1'b0;
        chk_signed = 1'b1;
        chk_w      = 6'd0;
        eff_imm    = a_imm_q;
`ifdef INST_ENC_PCREL_EN
        // Branch targets are relative to the address this instruction will be given.
        if (a_fmt_q == ENC_FMT_CB || a_fmt_q == ENC_FMT_B) begin
            eff_imm   = WORD'($signed(a_imm_q - WORD'(cnt_q)) >>> 2);
            align_bad = |a_imm_q[1:0];
        end
`endif
        case (a_fmt_q)
            ENC_FMT_I:     chk_w = 6'd12;
            ENC_FMT_D:     chk_w = 6'd9;
            ENC_FMT_CB:    chk_w = 6'd19;
            ENC_FMT_B:     chk_w = 6'd26;
            ENC_FMT_SHIFT: begin chk_w = 6'd6;  chk_signed = 1'b0; end
            ENC_FMT_IW:    begin chk_w = 6'd16; chk_signed = 1'b0; end
            ENC_FMT_R:     need_chk = 1'b0;
            default:       fmt_bad = 1'b1;
        endcase
    end

    imm_range_chk u_chk (
        .imm_i    (eff_imm),
        .width_i  (chk_w),
        .signed_i (chk_signed),
        .fits_o   (fits)
    );

    assign accept = a_adv && !fmt_bad && !align_bad && (!need_chk || fits);
    assign reject = a_adv && !accept;

    always_comb begin
        a_valid_d = a_valid_q;
        if (a_adv)                 a_valid_d = 1'b0;
        if (in_valid && in_ready)  a_valid_d = 1'b1;

        b_valid_d = b_valid_q;
        b_inst_d  = b_inst_q;
        b_addr_d  = b_addr_q;
        if (accept) begin
            b_valid_d = 1'b1;
            b_inst_d  = pack_inst(a_fmt_q, a_op_q, a_rd_q, a_rn_q, a_rm_q, eff_imm);
            b_addr_d  = cnt_q;
        end else if (out_ready) begin
            b_valid_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (accept)    cnt_d = cnt_q + ADDR_W'(4);
        if (addr_load) cnt_d = addr_init;

        err_pulse_d = reject;
        err_cnt_d   = err_cnt_q;
        if (reject && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q   <= 1'b0;
            a_fmt_q     <= ENC_FMT_R;
            a_op_q      <= '0;
            a_rd_q      <= '0;
            a_rn_q      <= '0;
            a_rm_q      <= '0;
            a_imm_q     <= '0;
            b_valid_q   <= 1'b0;
            b_inst_q    <= '0;
            b_addr_q    <= '0;
            cnt_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            b_valid_q   <= b_valid_d;
            b_inst_q    <= b_inst_d;
            b_addr_q    <= b_addr_d;
            cnt_q       <= cnt_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            if (in_valid && in_ready) begin
                a_fmt_q <= enc_fmt_e'(in_fmt);
                a_op_q  <= in_opcode;
                a_rd_q  <= in_rd;
                a_rn_q  <= in_rn;
                a_rm_q  <= in_rm;
                a_imm_q <= in_imm;
            end
        end
    end

    assign out_valid = b_valid_q;
    assign out_inst  = b_inst_q;
    assign out_addr  = b_addr_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard bench for inst_encoder with a range-based reference model
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  in_fmt;
    logic [10:0] in_opcode;
    logic [4:0]  in_rd, in_rn, in_rm;
    logic [63:0] in_imm;
    logic        addr_load;
    logic [63:0] addr_init;
    logic        out_valid, out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_addr;
    logic        err_pulse;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rn(in_rn),
        .in_rm(in_rm), .in_imm(in_imm), .addr_load(addr_load), .addr_init(addr_init),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    int          pulses = 0, pulse_base = 0, exp_errs = 0;
    logic [63:0] mcnt = '0;
    bit          stall = 0;
    logic [31:0] s_inst;
    logic [63:0] s_addr;
    exp_t        me;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Field-fit rules expressed as numeric ranges over the immediate value.
    function automatic void ref_model(input int fmt, input logic [10:0] op, input logic [4:0] rd,
                                      input logic [4:0] rn, input logic [4:0] rm,
                                      input logic [63:0] imm, input logic [63:0] addr,
                                      output bit ok, output logic [31:0] inst);
        longint v = longint'(imm);
        ok   = 1;
        inst = '0;
`ifdef INST_ENC_PCREL_EN
        if (fmt == 3 || fmt == 4) begin
            if (imm[1:0] != 2'b00) ok = 0;
            v = longint'(imm - addr) >>> 2;
        end
`endif
        case (fmt)
            0: inst = {op, rm, 6'b0, rn, rd};
            1: begin if (v < -2048 || v > 2047) ok = 0; inst = {op[10:1], v[11:0], rn, rd}; end
            2: begin if (v < -256 || v > 255) ok = 0; inst = {op, v[8:0], 2'b00, rn, rd}; end
            3: begin if (v < -262144 || v > 262143) ok = 0; inst = {op[10:3], v[18:0], rd}; end
            4: begin if (v < -33554432 || v > 33554431) ok = 0; inst = {op[10:5], v[25:0]}; end
            5: begin if (imm >= 64'd65536) ok = 0; inst = {op[10:2], 2'b00, imm[15:0], rd}; end
            6: begin if (imm >= 64'd64) ok = 0; inst = {op, 5'b0, imm[5:0], rn, rd}; end
            default: ok = 0;
        endcase
    endfunction

    task automatic send(input int fmt, input logic [10:0] op, input logic [4:0] rd,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [63:0] imm,
                        input bit lit_en, input logic [31:0] lit, input bit bp);
        bit          hs = 0;
        bit          ok;
        logic [31:0] inst;
        exp_t        e;
        in_fmt = 3'(fmt); in_opcode = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !hs; i++) begin
            if (bp) out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!hs) begin
            chk("handshake_timeout", 64'd0, 64'd1);
            return;
        end
        ref_model(fmt, op, rd, rn, rm, imm, mcnt, ok, inst);
        if (ok) begin
            e.inst = lit_en ? lit : inst;
            e.addr = mcnt;
            sb.push_back(e);
            mcnt = mcnt + 64'd4;
        end else begin
            exp_errs++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_errs(input string tag);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_errs));
        chk({tag, "_pulses"}, 64'(pulses - pulse_base), 64'(exp_errs));
    endtask

    task automatic load_addr(input logic [63:0] v);
        addr_init = v; addr_load = 1'b1;
        @(posedge clk); #1;
        addr_load = 1'b0;
        mcnt = v;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0; in_rn = '0;
        in_rm = '0; in_imm = '0; addr_load = 1'b0; addr_init = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_addr", out_addr, 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_err_pulse", 64'(err_pulse), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    stall = 0;
                end else begin
                    if (stall && out_valid) begin
                        chk("stall_inst", 64'(out_inst), 64'(s_inst));
                        chk("stall_addr", out_addr, s_addr);
                    end
                    if (err_pulse) pulses++;
                    if (out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_out", 64'(out_inst), 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            me = sb.pop_front();
                            chk("inst", 64'(out_inst), 64'(me.inst));
                            chk("addr", out_addr, me.addr);
                        end
                    end
                    stall  = out_valid && !out_ready;
                    s_inst = out_inst;
                    s_addr = out_addr;
                end
            end
        join_none

        send(1, OP_ADDI, 5'd1, 5'd2, 5'd0, 64'd5, 1, 32'h91001441, 0);
        @(negedge clk);
        chk("latency_edge1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_edge2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        send(2, OP_LDUR, 5'd3, 5'd4, 5'd0, -64'sd8, 1, 32'hF85F8083, 0);
`ifdef INST_ENC_PCREL_EN
        send(4, OP_B, 5'd0, 5'd0, 5'd0, 64'd20, 1, 32'h14000003, 0);
`else
        send(4, OP_B, 5'd0, 5'd0, 5'd0, 64'd3, 1, 32'h14000003, 0);
`endif
        send(1, OP_ADDI, 5'd1, 5'd2, 5'd0, 64'd2048, 0, 32'd0, 0);
        send(1, OP_ADDI, 5'd5, 5'd6, 5'd0, 64'd7, 0, 32'd0, 0);
        drain();
        check_errs("dir");

        load_addr(64'd0);
        out_ready = 1'b0;
        send(1, OP_ADDI, 5'd1, 5'd1, 5'd0, 64'd1, 0, 32'd0, 0);
        send(2, OP_LDUR, 5'd2, 5'd2, 5'd0, 64'd16, 0, 32'd0, 0);
        in_fmt = 3'd0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(0, 11'h458, 5'd3, 5'd4, 5'd5, 64'd0, 0, 32'd0, 0);
        drain();

        send(1, OP_ADDI, 5'd7, 5'd8, 5'd0, 64'd9, 0, 32'd0, 0);
        addr_init = 64'h100; addr_load = 1'b1;
        mcnt = 64'h100;
        @(posedge clk); #1;
        addr_load = 1'b0;
        send(5, 11'h694, 5'd9, 5'd0, 5'd0, 64'hBEEF, 0, 32'd0, 0);
        drain();

`ifdef INST_ENC_PCREL_EN
        load_addr(64'h10);
        send(3, OP_CBZ, 5'd0, 5'd0, 5'd0, 64'd0, 1, 32'hB4FFFF80, 0);
        send(3, OP_CBZ, 5'd0, 5'd0, 5'd0, 64'd2, 0, 32'd0, 0);
        drain();
`endif
        check_errs("addr");

        for (int n = 0; n < 300; n++) begin
            logic [63:0] imm;
            case ($urandom % 4)
                0: imm = 64'($signed(32'($urandom_range(0, 600)) - 32'sd300));
                1: imm = 64'($urandom % 5000);
                2: imm = {$urandom, $urandom};
                default: imm = 64'($urandom_range(0, 70000));
            endcase
            send(int'($urandom % 8), 11'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 imm, 0, 32'd0, 1);
        end
        drain();
        check_errs("rand");

        out_ready = 1'b0;
        send(1, OP_ADDI, 5'd1, 5'd2, 5'd0, 64'd3, 0, 32'd0, 0);
        send(1, OP_ADDI, 5'd1, 5'd2, 5'd0, 64'd4, 0, 32'd0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        mcnt = '0;
        exp_errs = 0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
        pulse_base = pulses;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(2, OP_LDUR, 5'd3, 5'd4, 5'd0, 64'd8, 0, 32'd0, 0);
        drain();
        check_errs("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Reverse of the ID-stage immediate extractor: packs an opcode, register fields and a 64-bit immediate into one 32-bit LEGv8 instruction word.
- Range-checks the immediate against its field width and assigns a byte address from an internal write pointer.
- Streams the result to instruction-memory fill logic (program loader / self-test generator) over a valid/ready interface.
- Two-stage pipeline: stage A holds the request and does the range check, stage B holds the packed output.

Parameters:
ADDR_W, 64, width of the address counter and out_addr.
ERR_CNT_W, 16, width of the saturating error counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
in_fmt  input  3  0=R, 1=I, 2=D, 3=CB, 4=B, 5=IW, 6=SHIFT, 7=reserved
in_opcode  input  11  opcode, left-justified; low bits unused per format
in_rd  input  5  Rd / Rt
in_rn  input  5  Rn
in_rm  input  5  Rm
in_imm  input  `WORD  immediate / shamt / branch operand
addr_load  input  1  load address counter
addr_init  input  ADDR_W  value loaded on addr_load
out_valid  output  1  packed instruction valid
out_ready  input  1  consumer ready
out_inst  output  `INST_SIZE  packed instruction
out_addr  output  ADDR_W  byte address assigned to out_inst
err_pulse  output  1  one-cycle pulse when a request is dropped
err_cnt  output  ERR_CNT_W  saturating count of dropped requests

Behaviour:
- Reset (rst=1 at an edge): A and B empty; out_valid=0, out_inst=0, out_addr=0, err_pulse=0, err_cnt=0, address counter=0. Reset mid-stream discards both stages without emitting anything.
- in_ready = !A_valid || A_adv.
- A_adv = A_valid && (!out_valid || out_ready).
- Latency: request handshake at edge t -> out_valid high in the cycle after edge t+1 (2 edges) when no backpressure.
- Stage B holds out_inst/out_addr stable while out_valid && !out_ready.
- Packing (bits MSB:LSB):
  - R: op[10:0] | Rm | 6'b0 | Rn | Rd.
  - SHIFT: op[10:0] | 5'b0 | imm[5:0] | Rn | Rd.
  - I: op[10:1] | imm[11:0] | Rn | Rd.
  - D: op[10:0] | imm[8:0] | 2'b00 | Rn | Rt.
  - CB: op[10:3] | imm[18:0] | Rt.
  - B: op[10:5] | imm[25:0].
  - IW: op[10:2] | 2'b00 | imm[15:0] | Rd.
- Range check on A_adv:
  - Signed fit required for I (12 bits), D (9), CB (19), B (26): imm[63:N-1] all equal.
  - Unsigned fit required for SHIFT (<64) and IW (<65536).
  - R ignores in_imm.
  - fmt=7 is always an error.
- Rejected request: consumed from A, not written to B; err_pulse=1 for one cycle; err_cnt+1, saturating at all-ones; address counter unchanged.
- Accepted request: B loaded; out_addr = counter; counter += 4, wrapping modulo 2^ADDR_W.
- addr_load: counter <= addr_init, overriding the increment. An instruction transferring in the same cycle receives the pre-load counter value.

Optional Feature:
- Macro: INST_ENC_PCREL_EN.
- Defined: for CB and B, in_imm is an absolute byte target.
  - Encoder computes offset = (in_imm - counter) >>> 2 (arithmetic shift) and range-checks the offset.
  - in_imm[1:0] != 0 is an error.
- Undefined: in_imm is already the word offset; no alignment check.

Decomposition:
- Shared common.vh: format codes ENC_FMT_R..ENC_FMT_IW plus ENC_FMT_RSVD; existing `WORD, `INST_SIZE and opcode macros (`ADDI, `LDUR, `CBZ, `B, ...).
- One natural sub-module: imm_range_chk. Combinational; inputs imm, width, signed flag; output fits. Instantiated once in stage A.

Test Plan:
- ADDI: fmt=I, op=10010001000, Rd=1, Rn=2, imm=5, addr=0 -> out_inst=0x91001441, out_addr=0, out_valid 2 edges after handshake.
- LDUR: fmt=D, op=11111000010, Rt=3, Rn=4, imm=-8 -> out_inst=0xF85F8083, out_addr=4.
- B: fmt=B, op=00010100000, imm=3 -> out_inst=0x14000003. Then ADDI imm=2048 -> no output, err_pulse one cycle, err_cnt=1, next valid instruction still gets the next sequential address.
- Backpressure: out_ready=0 for 6 cycles, offer 3 requests -> 2 accepted then in_ready=0. Release -> inst at addresses 0, 4, 8 in order, out_inst stable while stalled.
- addr_load with addr_init=0x100 on the same cycle as a transfer -> transferring inst at old address, next one at 0x100. Assert rst mid-stream -> out_valid=0 next cycle, err_cnt=0.
- (PCREL_EN) addr_init=0x10, CBZ op=10110100000, Rt=0, target=0x0 -> out_inst=0xB4FFFF80. Target 0x2 -> error.
